// File: rtl/digit_accumulator.sv
// digit_accumulator: Horner-style digit stream to integer converter with sign, radix and error reporting
module digit_accumulator #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 10,
    parameter int ASCII_MODE = 1,
    parameter int SIGNED_EN  = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        din,
    input  logic                              din_valid,
    input  logic                              end_num,
    input  logic                              hex_mode,
    output logic [WIDTH-1:0]                  result,
    output logic                              result_valid,
    output logic                              overflow_err,
    output logic                              digit_err,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              busy
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int PW = WIDTH + 5;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc, acc_b, acc_n;
    logic [CW-1:0]    cnt_b, cnt_n;
    logic             neg, neg_b, neg_n;
    logic             hex, hex_b;
    logic             ovf, ovf_b, ovf_n;
    logic             derr, derr_b, derr_n;
    logic             in_num, term, minus, is_dig, fin;
    logic [3:0]       dval;
    logic [PW-1:0]    acc_x, prod, lim;

    // Outside ACCUM every byte or strobe begins a fresh number, so start from cleared state.
    always_comb begin
        in_num = state == ACCUM;
        acc_b  = in_num ? acc : '0;
        cnt_b  = in_num ? digit_count : '0;
        neg_b  = in_num ? neg : 1'b0;
        hex_b  = in_num ? hex : hex_mode;
        ovf_b  = in_num ? ovf : 1'b0;
        derr_b = in_num ? derr : 1'b0;
        term   = (ASCII_MODE != 0) && (din == 8'h0D || din == 8'h0A);
        minus  = (ASCII_MODE != 0) && din == 8'h2D;
        if (ASCII_MODE != 0) begin
            is_dig = (din >= 8'h30 && din <= 8'h39) ||
                     (hex_b && ((din >= 8'h61 && din <= 8'h66) || (din >= 8'h41 && din <= 8'h46)));
            dval   = din[6] ? din[3:0] + 4'd9 : din[3:0];
        end else begin
            is_dig = din[7:4] == 4'd0 && (hex_b || din[3:0] < 4'd10);
            dval   = din[3:0];
        end
        acc_x  = {5'b0, acc_b};
        prod   = (hex_b ? acc_x << 4 : (acc_x << 3) + (acc_x << 1)) + PW'(dval);
        lim    = (SIGNED_EN == 0) ? {5'b0, {WIDTH{1'b1}}} :
                 neg_b ? PW'(1) << (WIDTH - 1) : (PW'(1) << (WIDTH - 1)) - PW'(1);
        acc_n  = acc_b;
        cnt_n  = cnt_b;
        neg_n  = neg_b;
        ovf_n  = ovf_b;
        derr_n = derr_b;
        if (din_valid && !term) begin
            if (minus && !in_num && SIGNED_EN != 0)
                neg_n = 1'b1;
            else if (!is_dig)
                derr_n = 1'b1;
            else if (cnt_b == CW'(MAX_DIGITS))
                ovf_n = 1'b1;
            else begin
                cnt_n = cnt_b + 1'b1;
                if (!ovf_b) begin
                    if (prod > lim)
                        ovf_n = 1'b1;
                    else
                        acc_n = prod[WIDTH-1:0];
                end
            end
        end
        fin = end_num || (din_valid && term);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            overflow_err <= 1'b0;
            digit_err    <= 1'b0;
            digit_count  <= '0;
            busy         <= 1'b0;
            acc          <= '0;
            neg          <= 1'b0;
            hex          <= 1'b0;
            ovf          <= 1'b0;
            derr         <= 1'b0;
        end else begin
            result_valid <= fin;
            busy         <= !fin && (din_valid || in_num);
            state        <= fin ? DONE : (din_valid || in_num) ? ACCUM : IDLE;
            if (din_valid || end_num) begin
                acc         <= acc_n;
                neg         <= neg_n;
                hex         <= hex_b;
                ovf         <= ovf_n;
                derr        <= derr_n;
                digit_count <= cnt_n;
            end
            if (fin) begin
                overflow_err <= ovf_n;
                digit_err    <= derr_n || cnt_n == '0;
                result       <= (ovf_n || derr_n || cnt_n == '0) ? '0 : neg_n ? -acc_n : acc_n;
            end
        end
    end
endmodule
